// File: rtl/stack_pkg.sv
// stack_pkg: opcode encodings shared by the stack datapath, its ALU and benches.
//   OP_NOP  3'b000  no operation (every unlisted code behaves the same way)
//   OP_ADD  3'b100  pop two, push sum
//   OP_MUL  3'b101  pop two, push product
//   OP_PUSH 3'b110  push data_in
//   OP_POP  3'b111  pop onto data_out
package stack_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

endpackage

// File: rtl/stack_alu.sv
// stack_alu: combinational add/multiply of two signed stack words.
//   a, b      in   signed operands (a = second from top, b = top)
//   is_mul    in   1 selects multiply, 0 selects add
//   result    out  low DATA_WIDTH bits of the selected operation
//   overflow  out  signed overflow of the selected operation
module stack_alu #(
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic                         is_mul,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         overflow
);

    logic signed [DATA_WIDTH-1:0]   sum;
    logic signed [2*DATA_WIDTH-1:0] wide_a;
    logic signed [2*DATA_WIDTH-1:0] wide_b;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic [DATA_WIDTH:0]            product_hi;
    logic                           add_ovf;
    logic                           mul_ovf;

    always_comb begin
        sum     = a + b;
        // Sign-extend explicitly so the product is computed at full width.
        wide_a  = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a});
        wide_b  = $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
        product = wide_a * wide_b;

        add_ovf = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                  (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);

        // The product fits in DATA_WIDTH signed bits only when the upper half
        // plus the result sign bit are all copies of one value.
        product_hi = product[2*DATA_WIDTH-1:DATA_WIDTH-1];
        mul_ovf    = !((&product_hi) || !(|product_hi));

        if (is_mul) begin
            result   = product[DATA_WIDTH-1:0];
            overflow = mul_ovf;
        end else begin
            result   = sum;
            overflow = add_ovf;
        end
    end

endmodule

// File: rtl/stack.sv
// stack: signed arithmetic stack executing one opcode per rising clock edge.
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (overrides any opcode)
//   opcode    in   operation select (see stack_pkg)
//   data_in   in   push operand
//   data_out  out  registered result of the last POP/ADD/MUL
//   empty     out  sp == 0
//   full      out  sp == STACK_DEPTH
//   overflow  out  registered signed overflow of the last ADD/MUL
// Illegal operations (push when full, pop when empty, arithmetic with fewer
// than two entries) leave every piece of state untouched.
module stack
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   opcode,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow
);

    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam int AW   = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(STACK_DEPTH);

    logic [SP_W-1:0]              sp;
    logic [SP_W-1:0]              sp_d;
    logic signed [DATA_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic signed [DATA_WIDTH-1:0] data_out_q;
    logic signed [DATA_WIDTH-1:0] data_out_d;
    logic                         overflow_q;
    logic                         overflow_d;

    logic                         mem_we;
    logic [AW-1:0]                mem_addr;
    logic signed [DATA_WIDTH-1:0] mem_wdata;

    logic [AW-1:0]                top_idx;
    logic [AW-1:0]                second_idx;
    logic signed [DATA_WIDTH-1:0] alu_a;
    logic signed [DATA_WIDTH-1:0] alu_b;
    logic signed [DATA_WIDTH-1:0] alu_result;
    logic                         alu_ovf;
    logic                         alu_is_mul;

    assign empty    = (sp == '0);
    assign full     = (sp == DEPTH_SP);
    assign data_out = data_out_q;
    assign overflow = overflow_q;

    // Operand indices wrap when sp is small; those reads are never used.
    assign top_idx    = AW'(sp - SP_W'(1));
    assign second_idx = AW'(sp - SP_W'(2));
    assign alu_a      = stack_mem[second_idx];
    assign alu_b      = stack_mem[top_idx];
    assign alu_is_mul = (opcode == OP_MUL);

    stack_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .is_mul   (alu_is_mul),
        .result   (alu_result),
        .overflow (alu_ovf)
    );

    always_comb begin
        sp_d       = sp;
        data_out_d = data_out_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_addr   = AW'(sp);
        mem_wdata  = data_in;

        case (opcode)
            OP_PUSH: begin
                if (!full) begin
                    mem_we = 1'b1;
                    sp_d   = sp + SP_W'(1);
                end
            end
            OP_POP: begin
                if (!empty) begin
                    data_out_d = stack_mem[top_idx];
                    sp_d       = sp - SP_W'(1);
                end
            end
            OP_ADD, OP_MUL: begin
                // Result replaces the second-from-top entry, which becomes top.
                if (sp >= SP_W'(2)) begin
                    mem_we     = 1'b1;
                    mem_addr   = second_idx;
                    mem_wdata  = alu_result;
                    data_out_d = alu_result;
                    overflow_d = alu_ovf;
                    sp_d       = sp - SP_W'(1);
                end
            end
            OP_NOP: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp         <= '0;
            data_out_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            sp         <= sp_d;
            data_out_q <= data_out_d;
            overflow_q <= overflow_d;
            if (mem_we) begin
                stack_mem[mem_addr] <= mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_stack.sv
// tb_stack: directed stimulus for the stack, checked every cycle against a
// queue-based reference model plus literal expectations for key results.
module tb_stack;

    localparam int W    = 8;
    localparam int D    = 16;
    localparam int MAXV = 127;
    localparam int MINV = -128;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] ADD  = 3'b100;
    localparam logic [2:0] MUL  = 3'b101;
    localparam logic [2:0] PUSH = 3'b110;
    localparam logic [2:0] POP  = 3'b111;

    logic                clk = 1'b0;
    logic                rst;
    logic [2:0]          opcode;
    logic signed [W-1:0] data_in;
    logic signed [W-1:0] data_out;
    logic                empty;
    logic                full;
    logic                overflow;

    int tests = 0;
    int fails = 0;

    int m_stack[$];
    int m_dout;
    int m_ovf;
    bit m_valid = 1'b0;
    int ma, mb, mr;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    stack #(
        .DATA_WIDTH  (W),
        .STACK_DEPTH (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    function automatic int wrap(input int v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return int'(t);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_stack.delete();
            m_dout  = 0;
            m_ovf   = 0;
            m_valid = 1'b1;
        end else if (rst === 1'b0) begin
            case (opcode)
                PUSH: if (m_stack.size() < D) m_stack.push_back(int'(data_in));
                POP:  if (m_stack.size() > 0) m_dout = m_stack.pop_back();
                ADD, MUL: begin
                    if (m_stack.size() >= 2) begin
                        mb = m_stack.pop_back();
                        ma = m_stack.pop_back();
                        mr = (opcode == ADD) ? ma + mb : ma * mb;
                        m_dout = wrap(mr);
                        m_ovf  = (mr > MAXV || mr < MINV) ? 1 : 0;
                        m_stack.push_back(m_dout);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("sp", int'(dut.sp), m_stack.size());
            chk("empty", int'(empty), (m_stack.size() == 0) ? 1 : 0);
            chk("full", int'(full), (m_stack.size() == D) ? 1 : 0);
            chk("data_out", int'(data_out), m_dout);
            chk("overflow", int'(overflow), m_ovf);
            for (int i = 0; i < m_stack.size(); i++)
                chk($sformatf("mem[%0d]", i), int'(dut.stack_mem[i]), m_stack[i]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_op(input logic [2:0] o, input int d);
        @(negedge clk);
        opcode  = o;
        data_in = W'(d);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        opcode = NOP;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic mul_case(input int a, input int b, input int exp_r, input int exp_o);
        do_op(PUSH, a);
        do_op(PUSH, b);
        do_op(MUL, 0);
        chk($sformatf("mul %0d*%0d", a, b), int'(data_out), exp_r);
        chk($sformatf("mul %0d*%0d ovf", a, b), int'(overflow), exp_o);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        opcode  = NOP;
        data_in = '0;
        do_reset();
        chk("reset empty", int'(empty), 1);
        chk("reset full", int'(full), 0);
        chk("reset data_out", int'(data_out), 0);
        chk("reset overflow", int'(overflow), 0);

        // Simple add.
        do_op(PUSH, 3);
        do_op(PUSH, 5);
        do_op(ADD, 0);
        chk("add 3+5", int'(data_out), 8);
        chk("add 3+5 ovf", int'(overflow), 0);
        chk("add 3+5 sp", int'(dut.sp), 1);

        // Add overflow both directions.
        do_op(PUSH, 127);
        do_op(PUSH, 2);
        do_op(ADD, 0);
        chk("add 127+2", int'(data_out), -127);
        chk("add 127+2 ovf", int'(overflow), 1);
        do_op(POP, 0);
        chk("pop -127", int'(data_out), -127);
        do_op(PUSH, -128);
        do_op(PUSH, -1);
        do_op(ADD, 0);
        chk("add -128+-1", int'(data_out), 127);
        chk("add -128+-1 ovf", int'(overflow), 1);
        do_op(POP, 0);
        chk("pop 127", int'(data_out), 127);

        // Unused opcodes act as NOP.
        do_op(3'b011, 55);
        do_op(NOP, 66);
        chk("nop holds data_out", int'(data_out), 127);

        // Multiply.
        mul_case(10, 12, 120, 0);
        mul_case(64, 3, -64, 1);
        mul_case(15, 15, -31, 1);
        mul_case(-20, -5, 100, 0);
        mul_case(7, -8, -56, 0);

        do_op(POP, 0);
        chk("pop -56", int'(data_out), -56);
        do_op(PUSH, 1);
        do_op(PUSH, 2);
        do_op(ADD, 0);
        chk("add 1+2", int'(data_out), 3);
        do_op(POP, 0);
        chk("pop 3", int'(data_out), 3);
        chk("final sp", int'(dut.sp), 5);
        chk("final mem0", int'(dut.stack_mem[0]), 8);
        chk("final mem1", int'(dut.stack_mem[1]), 120);
        chk("final mem2", int'(dut.stack_mem[2]), -64);
        chk("final mem3", int'(dut.stack_mem[3]), -31);
        chk("final mem4", int'(dut.stack_mem[4]), 100);

        // Fill, overfill, drain, underflow.
        do_reset();
        for (int i = 0; i < D; i++) do_op(PUSH, i * 3 - 20);
        chk("full after 16", int'(full), 1);
        do_op(PUSH, 99);
        chk("17th push sp", int'(dut.sp), 16);
        chk("17th push mem15", int'(dut.stack_mem[15]), 25);
        for (int i = 0; i < D; i++) do_op(POP, 0);
        chk("empty after drain", int'(empty), 1);
        chk("last pop", int'(data_out), -20);
        do_op(POP, 0);
        do_op(ADD, 0);
        chk("empty pop/add held", int'(data_out), -20);
        do_op(PUSH, 9);
        do_op(MUL, 0);
        chk("mul sp<2 sp", int'(dut.sp), 1);
        chk("mul sp<2 held", int'(data_out), -20);

        // Reset during push.
        do_op(PUSH, 100);
        do_op(PUSH, 50);
        do_op(ADD, 0);
        @(negedge clk);
        rst     = 1'b1;
        opcode  = PUSH;
        data_in = 8'sd77;
        @(posedge clk);
        #2;
        chk("rst push sp", int'(dut.sp), 0);
        chk("rst push data_out", int'(data_out), 0);
        chk("rst push overflow", int'(overflow), 0);
        chk("rst push empty", int'(empty), 1);
        rst = 1'b0;
        do_op(NOP, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stack.md
STACK -- requirements
Module: stack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each signed stack word.
REQ-002 SHALL have parameter STACK_DEPTH, default 16, number of entries.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port opcode  input  3  operation select, sampled each rising edge.
REQ-007 SHALL have port data_in  input  DATA_WIDTH signed  push operand.
REQ-008 SHALL have port data_out  output  DATA_WIDTH signed, registered  last pop or arithmetic result.
REQ-009 SHALL have port empty  output  1  high when sp == 0.
REQ-010 SHALL have port full  output  1  high when sp == STACK_DEPTH.
REQ-011 SHALL have port overflow  output  1, registered  signed overflow of the last add/multiply.
REQ-012 SHALL contain internal signals sp ($clog2(STACK_DEPTH)+1 bits, entry count) and stack_mem (STACK_DEPTH x DATA_WIDTH signed array), under exactly these names, for hierarchical inspection by benches.

Function
REQ-013 SHALL decode opcodes: 3'b110 PUSH, 3'b111 POP, 3'b100 ADD, 3'b101 MUL; 3'b000 and all other codes NOP.
REQ-014 SHALL take one clock per operation; results appear on data_out/overflow after the executing rising edge.
REQ-015 PUSH: stack_mem[sp] <= data_in, sp <= sp+1; data_out and overflow unchanged.
REQ-016 POP: data_out <= stack_mem[sp-1], sp <= sp-1; overflow unchanged.
REQ-017 ADD: A = stack_mem[sp-2], B = stack_mem[sp-1]; result = low DATA_WIDTH bits of A+B, written to stack_mem[sp-2] and data_out, sp <= sp-1.
REQ-018 ADD overflow SHALL be 1 when A and B share a sign and result sign differs, else 0.
REQ-019 MUL: as ADD but result = low DATA_WIDTH bits of the full 2*DATA_WIDTH signed product A*B.
REQ-020 MUL overflow SHALL be 1 when the full product lies outside the signed DATA_WIDTH range, else 0.
REQ-021 PUSH while full SHALL be ignored (no state change).
REQ-022 POP while empty SHALL be ignored (data_out held).
REQ-023 ADD/MUL with sp < 2 SHALL be ignored (no state change, overflow held).
REQ-024 NOP SHALL leave all state and outputs unchanged.
REQ-025 empty and full SHALL be combinational decodes of sp.

Reset
REQ-026 On a rising edge with rst=1: sp <= 0, data_out <= 0, overflow <= 0; rst SHALL override any opcode.
REQ-027 stack_mem contents SHALL not need reset (only indices below sp are meaningful).
REQ-028 After reset: empty=1, full=0.

Structure
REQ-029 Opcode constants (OP_NOP, OP_ADD, OP_MUL, OP_PUSH, OP_POP) SHALL live in shared package stack_pkg.
REQ-030 One combinational sub-module stack_alu SHALL compute add/mul result and overflow from A, B, and the op select.
REQ-031 Implementation SHALL use a single clocked process for sp, stack_mem, data_out, overflow.

Verification (8-bit, depth 16, opcode changed on falling edges)
REQ-032 Reset, push 3, push 5, ADD -> data_out=8, overflow=0, sp=1.
REQ-033 Push 127, push 2, ADD -> data_out=-127, overflow=1; POP -> data_out=-127; push -128, push -1, ADD -> data_out=127, overflow=1.
REQ-034 MUL: 10*12 -> 120, ovf 0; 64*3 -> -64, ovf 1; 15*15 -> -31, ovf 1; -20*-5 -> 100, ovf 0; 7*-8 -> -56, ovf 0.
REQ-035 Full sequence of REQ-032..034, then POP (-56), push 1, push 2, ADD (3), POP (3) -> sp=5, stack_mem[0..4] = 8,120,-64,-31,100.
REQ-036 Push 16 values -> full=1; 17th push ignored (sp=16); 16 pops -> empty=1; extra POP and ADD ignored, data_out held.
REQ-037 Assert rst during a PUSH cycle -> sp=0, data_out=0, overflow=0, empty=1 after that edge.
